program_loader: RTL and testbench

//   Writer side of the 16x8 program store. An operator enters a program from
//   the board switches, one byte per debounced ENTER press, into addresses 0..15.
//   The loader holds the CPU (cpu_hold) until loading ends, then releases it.

---
 rtl/program_loader.sv | 135 +++++++++++++
 tb/tb_program_loader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Program store writer: debounces ENTER/RUN buttons and writes switch words
// into consecutive addresses while holding the CPU, then releases it.

module program_loader_debounce #(
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise_p
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYC - 1);

  logic          sync_1;
  logic          sync_2;
  logic          level;
  logic [CW-1:0] cnt;

  // Down-counter runs only while the synced input disagrees with the level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      level  <= 1'b0;
      cnt    <= RELOAD;
      rise_p <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
      rise_p <= 1'b0;
      if (sync_2 == level) begin
        cnt <= RELOAD;
      end else if (cnt == '0) begin
        level  <= sync_2;
        rise_p <= sync_2;
        cnt    <= RELOAD;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// state   | meaning
// IDLE    | first cycle after reset
// ENTRY   | waiting for an ENTER or RUN pulse
// WRITE   | mem_we asserted for one cycle
// ADVANCE | count the write, step the address or finish
// DONE    | loading finished, CPU released until reset
module program_loader #(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 8,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              btn_enter,
  input  logic              btn_run,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   wr_count
);
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ENTRY   = 3'd1;
  localparam logic [2:0] ST_WRITE   = 3'd2;
  localparam logic [2:0] ST_ADVANCE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   MAX_COUNT = (ADDR_W+1)'(2**ADDR_W);

  logic [2:0] state;
  logic       pending_run;
  logic       enter_p;
  logic       run_p;

  program_loader_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_enter (
    .clk    (clk),
    .rst    (rst),
    .btn    (btn_enter),
    .rise_p (enter_p)
  );

  program_loader_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_run (
    .clk    (clk),
    .rst    (rst),
    .btn    (btn_run),
    .rise_p (run_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pending_run <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      wr_count    <= '0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_ENTRY;
        ST_ENTRY: begin
          if (enter_p) begin
            mem_wdata   <= sw_data;
            pending_run <= run_p;
            state       <= ST_WRITE;
          end else if (run_p) begin
            state <= ST_DONE;
          end
        end
        ST_WRITE: state <= ST_ADVANCE;
        ST_ADVANCE: begin
          if (wr_count != MAX_COUNT) wr_count <= wr_count + 1'b1;
          // The last address ends loading rather than wrapping back to 0.
          if (mem_addr == LAST_ADDR || pending_run) begin
            state <= ST_DONE;
          end else begin
            mem_addr <= mem_addr + 1'b1;
            state    <= ST_ENTRY;
          end
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_we    = (state == ST_WRITE);
  assign cpu_hold  = (state != ST_DONE);
  assign load_done = (state == ST_DONE);
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a scoreboard queue of expected writes
// is filled as presses are driven and drained as mem_we pulses appear.

module tb_program_loader;
  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw_data = 8'h00;
  logic       btn_enter = 1'b0;
  logic       btn_run = 1'b0;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       load_done;
  logic [4:0] wr_count;

  int n_assert = 0;
  int n_fail   = 0;

  logic [11:0] exp_q[$];
  logic [3:0]  m_addr;
  logic [4:0]  m_count;
  logic        m_done;

  program_loader #(.ADDR_W(4), .DATA_W(8), .DEBOUNCE_CYC(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_data   (sw_data),
    .btn_enter (btn_enter),
    .btn_run   (btn_run),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard drain: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      logic [11:0] e;
      check("we_with_hold", {31'd0, cpu_hold}, 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_write", {28'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {28'd0, mem_addr}, {28'd0, e[11:8]});
        check("wr_data", {24'd0, mem_wdata}, {24'd0, e[7:0]});
      end
    end
  end

  function automatic void model_write(input logic [7:0] d, input logic with_run);
    if (!m_done) begin
      exp_q.push_back({m_addr, d});
      m_count = m_count + 5'd1;
      if (m_addr == 4'hF || with_run) m_done = 1'b1;
      else m_addr = m_addr + 4'd1;
    end
  endfunction

  task automatic do_reset();
    btn_enter = 1'b0;
    btn_run   = 1'b0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_addr  = 4'd0;
    m_count = 5'd0;
    m_done  = 1'b0;
  endtask

  task automatic drive(input logic [7:0] d, input logic en, input logic rn, input int hold);
    sw_data   = d;
    btn_enter = en;
    btn_run   = rn;
    repeat (hold) @(negedge clk);
    btn_enter = 1'b0;
    btn_run   = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic press(input logic [7:0] d);
    model_write(d, 1'b0);
    drive(d, 1'b1, 1'b0, 8);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_pending"}, exp_q.size(), 32'd0);
    check({tag, "_addr"}, {28'd0, mem_addr}, {28'd0, m_addr});
    check({tag, "_count"}, {27'd0, wr_count}, {27'd0, m_count});
    check({tag, "_done"}, {31'd0, load_done}, {31'd0, m_done});
    check({tag, "_hold"}, {31'd0, cpu_hold}, {31'd0, ~m_done});
  endtask

  initial begin
    bit seen;
    @(negedge clk);
    // 1 reset
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", {28'd0, mem_addr}, 32'd0);
    check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
    check("rst_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_done", {31'd0, load_done}, 32'd0);
    check("rst_count", {27'd0, wr_count}, 32'd0);
    rst = 1'b0;

    // 2 single entry
    press(8'h1A);
    check_state("single");
    check("single_addr1", {28'd0, mem_addr}, 32'd1);

    // 3 bounce then hold gives one write; short press gives none
    model_write(8'h2B, 1'b0);
    sw_data = 8'h2B;
    btn_enter = 1'b1; @(negedge clk);
    btn_enter = 1'b0; @(negedge clk);
    btn_enter = 1'b1; @(negedge clk);
    drive(8'h2B, 1'b1, 1'b0, 10);
    check_state("bounce");
    drive(8'h3C, 1'b1, 1'b0, DEB - 1);
    check_state("short");

    // 4 full load of 16 words, then a 17th press is ignored
    do_reset();
    for (int i = 0; i < 16; i++) press(8'(i));
    check_state("full");
    check("full_count16", {27'd0, wr_count}, 32'd16);
    check("full_done", {31'd0, load_done}, 32'd1);
    press(8'hEE);
    check_state("after_full");

    // 5 early run after three writes
    do_reset();
    for (int i = 0; i < 3; i++) press(8'h40 + 8'(i));
    m_done = 1'b1;
    drive(8'h00, 1'b0, 1'b1, 8);
    check_state("early_run");
    check("early_run_cnt3", {27'd0, wr_count}, 32'd3);

    // 5b simultaneous ENTER+RUN at address 3
    do_reset();
    for (int i = 0; i < 3; i++) press(8'h50 + 8'(i));
    model_write(8'h5F, 1'b1);
    drive(8'h5F, 1'b1, 1'b1, 8);
    check_state("both");
    check("both_cnt4", {27'd0, wr_count}, 32'd4);

    // 6 reset during the WRITE cycle
    do_reset();
    model_write(8'h55, 1'b0);
    sw_data   = 8'h55;
    btn_enter = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (mem_we === 1'b1) seen = 1'b1;
    end
    check("midwr_seen", {31'd0, seen}, 32'd1);
    rst       = 1'b1;
    btn_enter = 1'b0;
    @(negedge clk);
    check("midwr_we", {31'd0, mem_we}, 32'd0);
    check("midwr_addr", {28'd0, mem_addr}, 32'd0);
    check("midwr_hold", {31'd0, cpu_hold}, 32'd1);
    check("midwr_count", {27'd0, wr_count}, 32'd0);
    rst = 1'b0;
    m_addr = 4'd0; m_count = 5'd0; m_done = 1'b0;
    repeat (12) @(negedge clk);
    m_done = 1'b1;
    drive(8'h00, 1'b0, 1'b1, 8);
    check_state("run_from_zero");

    // reset after DONE: IDLE then ENTRY on the following cycle
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_addr = 4'd0; m_count = 5'd0; m_done = 1'b0;
    check("post_done_idle", {29'd0, dut.state}, 32'd0);
    @(negedge clk);
    check("post_done_entry", {29'd0, dut.state}, 32'd1);
    check("post_done_hold", {31'd0, cpu_hold}, 32'd1);
    press(8'h77);
    check_state("post_done_write");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
